// File: rtl/mr2mmm_pkg.sv
// mr2mmm_pkg: shared definitions for the radix-2 Montgomery multiplier
// sequencing controller.
//   MODE_*          2-bit datapath register mode encodings (2'b11 unused)
//   mr2mmm_state_t  controller FSM states
package mr2mmm_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_LOAD = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;

   typedef enum logic [3:0] {
      IDLE,
      CLR,
      LOAD,
      ADD,
      SHIFT,
      UPD,
      SWAP,
      FIN,
      DONE
   } mr2mmm_state_t;

endpackage

// File: rtl/mr2mmm_ctrl_if.sv
// mr2mmm_ctrl_if: handshake and datapath-control bundle of the Montgomery
// multiplier controller.
//   start                          request from the BBS top level
//   busy, valid                    status back to the BBS top level
//   R1_en, SR1_en, SR2_en, done    2-bit register modes to the datapath
//   clrR1, clrR2, clrSR1, clrSR2   synchronous datapath clears
//   step                           pass select; rising edge latches S
// master = controller side, slave = datapath / BBS side.
interface mr2mmm_ctrl_if;
   logic       start;
   logic       busy;
   logic       valid;
   logic [1:0] R1_en;
   logic [1:0] SR1_en;
   logic [1:0] SR2_en;
   logic [1:0] done;
   logic       clrR1;
   logic       clrR2;
   logic       clrSR1;
   logic       clrSR2;
   logic       step;

   modport master (
      input  start,
      output busy, valid, R1_en, SR1_en, SR2_en, done,
      output clrR1, clrR2, clrSR1, clrSR2, step
   );

   modport slave (
      output start,
      input  busy, valid, R1_en, SR1_en, SR2_en, done,
      input  clrR1, clrR2, clrSR1, clrSR2, step
   );
endinterface

// File: rtl/mr2mmm_ctrl_iter_counter.sv
// iter_counter: per-pass iteration counter.
//   clk, rst  clock, asynchronous active-high reset
//   clr       synchronous clear to 0
//   inc       increment by one
//   last      count equals ITERS-1 (final iteration of a pass)
// One extra bit over $clog2(ITERS) so the count can reach ITERS without
// wrapping.
module iter_counter #(
   parameter int ITERS = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic last
);
   localparam int W = $clog2(ITERS) + 1;
   localparam logic [W-1:0] LAST_VAL = W'(ITERS - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc)
         count <= count + 1'b1;
   end

   assign last = (count == LAST_VAL);
endmodule

// File: rtl/mr2mmm_ctrl.sv
// mr2mmm_ctrl: sequencing controller for the radix-2 Montgomery multiplier.
// Computes A*B*C*R^-2 mod N as two passes (S = C*B*R^-1, then A*S*R^-1),
// driving every mode, clear and step input of the datapath.
//   clk, rst  clock, asynchronous active-high reset
//   bus       mr2mmm_ctrl_if.master: start/busy/valid handshake, register
//             modes, clears and the registered pass select step
// All outputs are decoded from state or registered; start only affects
// the next-state logic.
module mr2mmm_ctrl
   import mr2mmm_pkg::*;
#(
   parameter int M     = 8,
   parameter int ITERS = M
) (
   input  logic          clk,
   input  logic          rst,
   mr2mmm_ctrl_if.master bus
);
   mr2mmm_state_t state, nstate;
   logic          step_q, step_nxt;
   logic          cnt_clr, cnt_inc, cnt_last;

   iter_counter #(.ITERS(ITERS)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .last (cnt_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         step_q <= 1'b0;
      end else begin
         state  <= nstate;
         step_q <= step_nxt;
      end
   end

   assign bus.step = step_q;

   always_comb begin
      nstate     = state;
      step_nxt   = step_q;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      bus.busy   = (state != IDLE);
      bus.valid  = 1'b0;
      bus.R1_en  = MODE_HOLD;
      bus.SR1_en = MODE_HOLD;
      bus.SR2_en = MODE_HOLD;
      bus.done   = MODE_HOLD;
      bus.clrR1  = 1'b0;
      bus.clrR2  = 1'b0;
      bus.clrSR1 = 1'b0;
      bus.clrSR2 = 1'b0;
      unique case (state)
         IDLE: if (bus.start) nstate = CLR;
         CLR: begin
            bus.clrR1  = 1'b1;
            bus.clrSR1 = 1'b1;
            bus.clrSR2 = 1'b1;
            // R2 is cleared only at the start of pass 0; it is a Moore
            // decode of CLR so start never reaches an output directly.
            bus.clrR2  = ~step_q;
            cnt_clr    = 1'b1;
            nstate     = LOAD;
         end
         LOAD: begin
            bus.SR1_en = MODE_LOAD;
            nstate     = ADD;
         end
         ADD: begin
            bus.SR2_en = MODE_LOAD;
            nstate     = SHIFT;
         end
         SHIFT: begin
            bus.SR2_en = MODE_SHR;
            nstate     = UPD;
         end
         UPD: begin
            bus.R1_en  = MODE_LOAD;
            bus.SR1_en = MODE_SHR;
            cnt_inc    = 1'b1;
            if (cnt_last)
               nstate = step_q ? FIN : SWAP;
            else
               nstate = ADD;
         end
         SWAP: begin
            // R1 is untouched here, so pass-0 S is stable when step rises.
            step_nxt = 1'b1;
            nstate   = CLR;
         end
         FIN: begin
            bus.done = MODE_LOAD;
            nstate   = DONE;
         end
         DONE: begin
            bus.valid = 1'b1;
            step_nxt  = 1'b0;
            nstate    = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mr2mmm_ctrl.sv
module tb_mr2mmm_ctrl;
   import mr2mmm_pkg::*;

   localparam int ITERS = 8;
   localparam logic [15:0] N = 16'd239;
   localparam logic [15:0] OPA = 16'd1, OPB = 16'd1, OPC = 16'd1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mr2mmm_ctrl_if bus ();

   mr2mmm_ctrl #(.M(8), .ITERS(ITERS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   // Behavioural radix-2 Montgomery datapath driven by the controller.
   logic [15:0] R1, R2, SR1, SR2, S, m2, t, add_v;
   always_comb begin
      m2    = bus.step ? S : OPB;
      t     = R1 + (SR1[0] ? m2 : 16'd0);
      add_v = t + (t[0] ? N : 16'd0);
   end

   always @(posedge clk) begin
      if (bus.clrR1) R1 <= '0;
      else if (bus.R1_en == MODE_LOAD) R1 <= SR2;
      if (bus.clrSR1) SR1 <= '0;
      else if (bus.SR1_en == MODE_LOAD) SR1 <= bus.step ? OPA : OPC;
      else if (bus.SR1_en == MODE_SHR) SR1 <= SR1 >> 1;
      if (bus.clrSR2) SR2 <= '0;
      else if (bus.SR2_en == MODE_LOAD) SR2 <= add_v;
      else if (bus.SR2_en == MODE_SHR) SR2 <= SR2 >> 1;
      if (bus.clrR2) R2 <= '0;
      else if (bus.done == MODE_LOAD) R2 <= (R1 >= N) ? R1 - N : R1;
   end

   always @(posedge bus.step) S <= R1;

   // Vector record: inputs (gap, hold) and expected per-operation results.
   typedef struct {
      int gap;
      int hold;
      int valid_cyc;
      int busy_len;
      int upd;
      int loads;
      int clrs;
      int step_rise;
      int step_len;
      int res_mod;
   } vec_t;

   vec_t vecs[3];
   vec_t q[$];

   // Monitor / scoreboard, sampled on the falling edge.
   bit active = 0, pend = 0, busy_prev = 0, sb_en = 1;
   int cyc, busy_len, upd, loads, clrs, step_rise, step_len;
   int viol = 0;

   always @(negedge clk) begin
      if (bus.R1_en == 2'b11 || bus.SR1_en == 2'b11 ||
          bus.SR2_en == 2'b11 || bus.done == 2'b11) viol++;
      if ((bus.clrR1 && bus.R1_en == MODE_LOAD) ||
          (bus.clrSR1 && bus.SR1_en == MODE_LOAD) ||
          (bus.clrSR2 && bus.SR2_en == MODE_LOAD) ||
          (bus.clrR2 && bus.done == MODE_LOAD)) viol++;
      if (rst) begin
         active = 0;
         pend   = 0;
      end else begin
         if (pend) begin
            chk("post_valid_valid", bus.valid, 0);
            chk("post_valid_step", bus.step, 0);
            chk("post_valid_busy", bus.busy, 0);
            pend = 0;
         end
         if (bus.busy && !busy_prev) begin
            active = 1; cyc = 0; busy_len = 0; upd = 0; loads = 0;
            clrs = 0; step_rise = 0; step_len = 0;
         end
         if (active) begin
            cyc++;
            if (bus.busy) busy_len++;
            if (bus.R1_en == MODE_LOAD) upd++;
            if (bus.SR1_en == MODE_LOAD) loads++;
            if (bus.clrR1) clrs++;
            if (bus.step) begin
               step_len++;
               if (step_rise == 0) step_rise = cyc;
            end
            if (bus.valid) begin
               active = 0;
               pend   = 1;
               if (sb_en) begin
                  if (q.size() == 0) chk("sb_unexpected_valid", 1, 0);
                  else begin
                     vec_t e;
                     e = q.pop_front();
                     chk("valid_cycle", cyc, e.valid_cyc);
                     chk("busy_len", busy_len, e.busy_len);
                     chk("upd_count", upd, e.upd);
                     chk("sr1_loads", loads, e.loads);
                     chk("clr_count", clrs, e.clrs);
                     chk("step_rise", step_rise, e.step_rise);
                     chk("step_len", step_len, e.step_len);
                     chk("result_mod", int'(R2) % 239, e.res_mod);
                     chk("result_lt_2n", int'(R2 < 2 * N), 1);
                  end
               end
            end
         end
      end
      busy_prev = rst ? 1'b0 : bus.busy;
   end

   function automatic int outs();
      return int'({bus.busy, bus.valid, bus.R1_en, bus.SR1_en, bus.SR2_en,
                   bus.done, bus.clrR1, bus.clrR2, bus.clrSR1, bus.clrSR2,
                   bus.step});
   endfunction

   task automatic run_vec(input vec_t v);
      int k;
      repeat (v.gap) @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      q.push_back(v);
      if (v.hold != 0) q.push_back(v);
      @(posedge clk);
      @(negedge clk);
      if (v.hold == 0) bus.start = 1'b0;
      else begin
         k = 0;
         while (!bus.valid && k < 200) begin @(negedge clk); k++; end
         if (k >= 200) chk("hold_valid_timeout", 0, 1);
         @(negedge clk);
         chk("hold_idle_busy", bus.busy, 0);
         @(negedge clk);
         chk("hold_rebusy", bus.busy, 1);
         bus.start = 1'b0;
      end
      k = 0;
      while (bus.busy && k < 200) begin @(negedge clk); k++; end
      if (k >= 200) chk("op_timeout", 0, 1);
   endtask

   initial begin
      for (int i = 0; i < 3; i++)
         vecs[i] = '{gap: 0, hold: 0, valid_cyc: 7 + 6 * ITERS,
                     busy_len: 7 + 6 * ITERS, upd: 2 * ITERS, loads: 2,
                     clrs: 2, step_rise: 4 + 3 * ITERS,
                     step_len: 4 + 3 * ITERS, res_mod: 196};
      vecs[1].gap  = 5;
      vecs[2].gap  = 1;
      vecs[2].hold = 1;

      bus.start = 1'b0;
      rst = 1'b1;
      #1 chk("reset_outs_t0", outs(), 0);
      repeat (3) begin
         @(negedge clk);
         chk("reset_outs_held", outs(), 0);
      end
      rst = 1'b0;

      for (int i = 0; i < 3; i++) run_vec(vecs[i]);

      // Abort at cycle 30 with an asynchronous reset between edges.
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (29) @(negedge clk);
      chk("abort_c30_busy", bus.busy, 1);
      chk("abort_c30_step", bus.step, 1);
      #2 rst = 1'b1;
      #1 chk("abort_outs_immediate", outs(), 0);
      @(negedge clk);
      chk("abort_outs_held", outs(), 0);
      rst = 1'b0;
      run_vec(vecs[0]);

      // Random start/reset sequences; only legality is tracked here.
      sb_en = 0;
      for (int i = 0; i < 100; i++) begin
         int len;
         len = $urandom_range(5, 80);
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            bus.start = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) begin
               #2 rst = 1'b1;
               #1 chk("rand_rst_outs", outs(), 0);
               @(negedge clk);
               rst = 1'b0;
            end
         end
      end
      bus.start = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      sb_en = 1;
      run_vec(vecs[1]);

      repeat (3) @(negedge clk);
      chk("mode_legality_violations", viol, 0);
      chk("scoreboard_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
